// File: rtl/sfx_tone_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// sfx_tone_sequencer_pkg
// Shared definitions for the speaker tone sequencer: effect identifiers,
// note frequencies in Hz, FSM state encoding, tone-word width and a small
// priority helper.
// ---------------------------------------------------------------------------
package sfx_tone_sequencer_pkg;

    localparam int TONE_W = 32;

    typedef logic [1:0] effect_t;

    // Numeric order doubles as priority order: a larger id always wins.
    localparam effect_t EFF_NONE  = 2'd0;
    localparam effect_t EFF_HIT   = 2'd1;
    localparam effect_t EFF_SCORE = 2'd2;
    localparam effect_t EFF_OVER  = 2'd3;

    localparam logic [TONE_W-1:0] NOTE_REST = 32'd0;
    localparam logic [TONE_W-1:0] NOTE_C4   = 32'd262;
    localparam logic [TONE_W-1:0] NOTE_G4   = 32'd392;
    localparam logic [TONE_W-1:0] NOTE_C5   = 32'd523;
    localparam logic [TONE_W-1:0] NOTE_E5   = 32'd659;
    localparam logic [TONE_W-1:0] NOTE_G5   = 32'd784;
    localparam logic [TONE_W-1:0] NOTE_A5   = 32'd880;
    localparam logic [TONE_W-1:0] NOTE_C6   = 32'd1047;
    localparam logic [TONE_W-1:0] NOTE_E6   = 32'd1319;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP
    } seq_state_e;

    // Higher-priority of two effect ids; EFF_NONE (0) loses to anything.
    function automatic effect_t maxEffect(input effect_t a, input effect_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sfx_tone_sequencer_if.sv
// ---------------------------------------------------------------------------
// sfx_tone_sequencer_if
// Game-event / tone bundle between the game logic (master) and one speaker
// channel sequencer (slave).
//   ev_hit, ev_score, ev_over : one-cycle effect requests (master -> slave)
//   mute                      : level, silences tone       (master -> slave)
//   tone                      : note frequency in Hz       (slave -> master)
//   busy, effect_id, done     : playback status            (slave -> master)
// ---------------------------------------------------------------------------
interface sfx_tone_sequencer_if;
    import sfx_tone_sequencer_pkg::*;

    logic              ev_hit;
    logic              ev_score;
    logic              ev_over;
    logic              mute;
    logic [TONE_W-1:0] tone;
    logic              busy;
    effect_t           effect_id;
    logic              done;

    modport master (
        output ev_hit, ev_score, ev_over, mute,
        input  tone, busy, effect_id, done
    );

    modport slave (
        input  ev_hit, ev_score, ev_over, mute,
        output tone, busy, effect_id, done
    );

endinterface

// File: rtl/sfx_tone_sequencer_note_rom.sv
// ---------------------------------------------------------------------------
// sfx_note_rom
// Combinational note table: (effect, note index) -> {tone in Hz, last flag}.
//   effect_id_i : effect to look up
//   index_i     : note position within the effect
//   tone_o      : note frequency in Hz (0 = rest)
//   last_o      : this index is the final note of the effect
// Unknown effects or indices read as a silent final note so the sequencer
// can never run past the end of a table.
// ---------------------------------------------------------------------------
module sfx_note_rom
    import sfx_tone_sequencer_pkg::*;
(
    input  effect_t           effect_id_i,
    input  logic [2:0]        index_i,
    output logic [TONE_W-1:0] tone_o,
    output logic              last_o
);

    // Table lookup; defaults give a silent terminating entry.
    always_comb begin
        tone_o = NOTE_REST;
        last_o = 1'b1;
        case (effect_id_i)
            EFF_HIT: begin
                case (index_i)
                    3'd0:    begin tone_o = NOTE_A5; last_o = 1'b0; end
                    3'd1:    begin tone_o = NOTE_E6; last_o = 1'b1; end
                    default: ;
                endcase
            end
            EFF_SCORE: begin
                case (index_i)
                    3'd0:    begin tone_o = NOTE_C5; last_o = 1'b0; end
                    3'd1:    begin tone_o = NOTE_E5; last_o = 1'b0; end
                    3'd2:    begin tone_o = NOTE_G5; last_o = 1'b0; end
                    3'd3:    begin tone_o = NOTE_C6; last_o = 1'b1; end
                    default: ;
                endcase
            end
            EFF_OVER: begin
                case (index_i)
                    3'd0:    begin tone_o = NOTE_G5;   last_o = 1'b0; end
                    3'd1:    begin tone_o = NOTE_E5;   last_o = 1'b0; end
                    3'd2:    begin tone_o = NOTE_C5;   last_o = 1'b0; end
                    3'd3:    begin tone_o = NOTE_G4;   last_o = 1'b0; end
                    3'd4:    begin tone_o = NOTE_REST; last_o = 1'b0; end
                    3'd5:    begin tone_o = NOTE_C4;   last_o = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sfx_tone_sequencer.sv
// ---------------------------------------------------------------------------
// sfx_tone_sequencer
// Turns one-cycle game events into timed note sequences for one speaker
// channel. Each note lasts TICKS cycles: TICKS-TICKS/GAP_DIV cycles sounding
// followed by a silent articulation gap. Handles effect priority,
// preemption and a one-deep pending request.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : sfx_tone_sequencer_if.slave (events, mute in; tone/status out)
// ---------------------------------------------------------------------------
module sfx_tone_sequencer
    import sfx_tone_sequencer_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BEAT_FREQ = 8,
    parameter int GAP_DIV   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sfx_tone_sequencer_if.slave bus
);

    localparam int TICKS    = CLK_FREQ / BEAT_FREQ;
    localparam int GAP_LEN  = TICKS / GAP_DIV;
    localparam int PLAY_LEN = TICKS - GAP_LEN;
    localparam int CNT_W    = $clog2(TICKS);

    localparam logic [CNT_W-1:0] PLAY_END = CNT_W'(PLAY_LEN - 1);
    localparam logic [CNT_W-1:0] NOTE_END = CNT_W'(TICKS - 1);

    seq_state_e        state_q,    state_d;
    logic [CNT_W-1:0]  tickCnt_q,  tickCnt_d;
    logic [2:0]        noteIdx_q,  noteIdx_d;
    effect_t           curEff_q,   curEff_d;
    effect_t           pendEff_q,  pendEff_d;
    logic              lastNote_q, lastNote_d;
    logic [TONE_W-1:0] tone_q,     tone_d;

    effect_t           evTop;
    effect_t           evSecond;
    effect_t           startEff;
    logic              effEnd;
    logic [TONE_W-1:0] romTone;

    // The ROM is addressed with the next-state effect/index so the tone
    // register and the last-note flag are ready on the same edge the note
    // begins.
    sfx_note_rom u_rom (
        .effect_id_i (curEff_d),
        .index_i     (noteIdx_d),
        .tone_o      (romTone),
        .last_o      (lastNote_d)
    );

    // Rank this cycle's events: evTop starts or preempts, evSecond is the
    // only other one that can be kept (as pending).
    always_comb begin
        evTop    = EFF_NONE;
        evSecond = EFF_NONE;
        if (bus.ev_over) begin
            evTop = EFF_OVER;
            if (bus.ev_score)    evSecond = EFF_SCORE;
            else if (bus.ev_hit) evSecond = EFF_HIT;
        end else if (bus.ev_score) begin
            evTop = EFF_SCORE;
            if (bus.ev_hit) evSecond = EFF_HIT;
        end else if (bus.ev_hit) begin
            evTop = EFF_HIT;
        end
    end

    // Next-state logic. startEff != NONE means "begin this effect at note 0
    // on the next edge", whether from idle, preemption or effect end.
    always_comb begin
        state_d   = state_q;
        tickCnt_d = tickCnt_q;
        noteIdx_d = noteIdx_q;
        curEff_d  = curEff_q;
        pendEff_d = pendEff_q;
        startEff  = EFF_NONE;
        effEnd    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (evTop != EFF_NONE) begin
                    startEff  = evTop;
                    pendEff_d = evSecond;
                end
            end
            ST_PLAY, ST_GAP: begin
                effEnd = (state_q == ST_GAP) && (tickCnt_q == NOTE_END) && lastNote_q;
                if (effEnd) begin
                    // Best of {pending, events} starts; the runner-up is kept.
                    if (pendEff_q > evTop) begin
                        startEff  = pendEff_q;
                        pendEff_d = evTop;
                    end else begin
                        startEff  = evTop;
                        pendEff_d = maxEffect(pendEff_q, evSecond);
                    end
                    if (startEff == EFF_NONE) begin
                        state_d   = ST_IDLE;
                        curEff_d  = EFF_NONE;
                        tickCnt_d = '0;
                        noteIdx_d = '0;
                    end
                end else if (evTop > curEff_q) begin
                    // Preemption: the interrupted effect is simply dropped.
                    startEff  = evTop;
                    pendEff_d = maxEffect(pendEff_q, evSecond);
                end else begin
                    pendEff_d = maxEffect(pendEff_q, evTop);
                    if (state_q == ST_PLAY) begin
                        if (tickCnt_q == PLAY_END) state_d = ST_GAP;
                        tickCnt_d = tickCnt_q + CNT_W'(1);
                    end else if (tickCnt_q == NOTE_END) begin
                        state_d   = ST_PLAY;
                        tickCnt_d = '0;
                        noteIdx_d = noteIdx_q + 3'd1;
                    end else begin
                        tickCnt_d = tickCnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (startEff != EFF_NONE) begin
            state_d   = ST_PLAY;
            tickCnt_d = '0;
            noteIdx_d = '0;
            curEff_d  = startEff;
        end
    end

    // Tone is only audible while a note is sounding and the channel is not
    // muted; sequencing carries on regardless of mute.
    always_comb begin
        tone_d = '0;
        if ((state_d == ST_PLAY) && !bus.mute) tone_d = romTone;
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tickCnt_q  <= '0;
            noteIdx_q  <= '0;
            curEff_q   <= EFF_NONE;
            pendEff_q  <= EFF_NONE;
            lastNote_q <= 1'b0;
            tone_q     <= '0;
        end else begin
            state_q    <= state_d;
            tickCnt_q  <= tickCnt_d;
            noteIdx_q  <= noteIdx_d;
            curEff_q   <= curEff_d;
            pendEff_q  <= pendEff_d;
            lastNote_q <= lastNote_d;
            tone_q     <= tone_d;
        end
    end

    assign bus.tone      = tone_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.effect_id = curEff_q;
    assign bus.done      = effEnd;

endmodule
